// File: rtl/crc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// crc_frame_ctrl
//
// Sequencer in front of the shared crc_192bits engine. It packs WORDS input
// words of WORD_W bits into one 176-bit payload (first word in the MSBs),
// holds that payload stable on the engine input while the engine computes,
// captures the 192-bit payload+CRC codeword, checks that the engine echoed
// the payload unchanged, and presents the codeword downstream with
// valid/ready flow control.
//
// Parameters
//   WORD_W       input word width (16)
//   WORDS        words per payload (11); WORD_W*WORDS must be 176
//   CRC_LATENCY  clock edges from a stable crc_data_in to a valid
//                crc_data_out, counting the capture edge; must be >= 1
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-high
//   in_data       in   payload word
//   in_valid      in   in_data is valid
//   in_ready      out  a word is accepted this cycle if in_valid is high
//   in_abort      in   discard the partial payload (only while filling)
//   crc_data_in   out  payload driven into the engine's data_in
//   crc_data_out  in   codeword from the engine's data_out
//   out_data      out  captured codeword
//   out_valid     out  out_data is valid
//   out_ready     in   downstream accepts out_data
//   frame_cnt     out  number of delivered codewords, wraps at 16 bits
//   err_echo      out  sticky: engine returned a payload different from ours
// -----------------------------------------------------------------------------
module crc_frame_ctrl #(
    parameter int WORD_W      = 16,
    parameter int WORDS       = 11,
    parameter int CRC_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_abort,
    output logic [WORD_W*WORDS-1:0]      crc_data_in,
    input  logic [WORD_W*WORDS+16-1:0]   crc_data_out,
    output logic [WORD_W*WORDS+16-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  frame_cnt,
    output logic                         err_echo
);

    localparam int PAYLOAD_W = WORD_W * WORDS;
    localparam int CODE_W    = PAYLOAD_W + 16;
    localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W     = (CRC_LATENCY > 1) ? $clog2(CRC_LATENCY) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_LATENCY - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  word_idx;
    logic [CNT_W-1:0]  wait_cnt;

    logic              accept;
    logic              abort_fill;
    logic              last_word;
    logic              capture;
    logic              handshake;
    logic              echo_bad;

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        abort_fill = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;

        case (state)
            FILL: begin
                // Abort wins over a word presented in the same cycle, so that
                // word is dropped rather than written into the new payload.
                if (in_abort) begin
                    abort_fill = 1'b1;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (word_idx == LAST_IDX) begin
                        next_state = WAIT;
                    end
                end
            end

            WAIT: begin
                if (wait_cnt == LAST_CNT) begin
                    capture    = 1'b1;
                    next_state = OUT;
                end
            end

            OUT: begin
                // out_ready only matters once the codeword is on offer.
                if (out_valid && out_ready) begin
                    handshake  = 1'b1;
                    next_state = FILL;
                end
            end

            default: begin
                next_state = FILL;
            end
        endcase
    end

    assign last_word = (word_idx == LAST_IDX);

    // The engine must return our payload verbatim in the upper bits.
    assign echo_bad = (crc_data_out[CODE_W-1:16] != crc_data_in);

    // Held low while reset is asserted; FILL is the reset state, so the
    // controller is ready as soon as reset is released.
    assign in_ready = (state == FILL) && !rst;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Fill side: word index and payload register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
        end else if (abort_fill || handshake) begin
            word_idx <= '0;
        end else if (accept) begin
            word_idx <= last_word ? '0 : IDX_W'(word_idx + 1'b1);
        end
    end

    // Each accepted word overwrites only its own slot; the rest of the
    // payload keeps whatever it held, including the previous frame's words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_data_in <= '0;
        end else if (accept) begin
            for (int k = 0; k < WORDS; k++) begin
                if (word_idx == IDX_W'(k)) begin
                    crc_data_in[PAYLOAD_W-1-WORD_W*k -: WORD_W] <= in_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Wait side: latency counter, cleared as the last word is accepted
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept && last_word) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= CNT_W'(wait_cnt + 1'b1);
        end
    end

    // -------------------------------------------------------------------------
    // Output side: codeword capture, valid flag, frame counter, echo flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (capture) begin
            out_data <= crc_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (handshake) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_echo <= 1'b0;
        end else if (capture && echo_bad) begin
            err_echo <= 1'b1;
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for crc_frame_ctrl: drives frames of 11 words, models the CRC engine
// as a one-register pipeline (CRC-16/CCITT appended to the payload), keeps a
// queue of expected codewords and compares each delivered codeword against it.
// -----------------------------------------------------------------------------
module tb_crc_frame_ctrl;

    localparam int WORD_W = 16;
    localparam int WORDS  = 11;
    localparam int LAT    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_abort = 1'b0;
    logic [175:0]  crc_data_in;
    logic [191:0]  crc_data_out;
    logic [191:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   frame_cnt;
    logic          err_echo;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [191:0]  exp_q[$];
    logic [15:0]   exp_cnt = '0;
    logic          inject = 1'b0;
    logic [191:0]  eng_q = '0;

    crc_frame_ctrl #(
        .WORD_W      (WORD_W),
        .WORDS       (WORDS),
        .CRC_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_abort     (in_abort),
        .crc_data_in  (crc_data_in),
        .crc_data_out (crc_data_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_cnt    (frame_cnt),
        .err_echo     (err_echo)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc16(input logic [175:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 175; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [191:0] codeword(input logic [175:0] p, input logic flip);
        logic [191:0] cw;
        cw = {p, crc16(p)};
        if (flip) cw[100] = ~cw[100];
        return cw;
    endfunction

    // Engine model: one register stage, so a payload stable after edge N is
    // seen on crc_data_out from edge N+1 and captured at edge N+2.
    always @(posedge clk) eng_q <= codeword(crc_data_in, inject);
    assign crc_data_out = eng_q;

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        int waited;
        waited   = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 192'(in_ready), 192'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [175:0] p, input int gap_after, input bit push);
        if (push) exp_q.push_back(codeword(p, inject));
        for (int k = 0; k < WORDS; k++) begin
            send_word(p[175-16*k -: 16]);
            if (k == gap_after) begin
                repeat (3) begin @(posedge clk); #1; end
            end
        end
    endtask

    // Counts edges from the accept edge of the last word until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 192'(out_valid), 192'(1'b1));
    endtask

    task automatic compare_out(input string tag);
        logic [191:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 192'(exp_q.size()), 192'(1));
        end else begin
            e = exp_q.pop_front();
            check(tag, out_data, e);
        end
    endtask

    // Handshake must complete in exactly one edge once out_ready is high.
    task automatic finish_frame(input string tag);
        int cyc;
        cyc = 0;
        while (out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        exp_cnt = exp_cnt + 16'd1;
        check({tag, "_hs_cycles"}, 192'(cyc), 192'(1));
        check({tag, "_frame_cnt"}, 192'(frame_cnt), 192'(exp_cnt));
        check({tag, "_in_ready_back"}, 192'(in_ready), 192'(1'b1));
    endtask

    task automatic run_frame(input string tag, input logic [175:0] p, input int gap_after);
        int lat;
        send_frame(p, gap_after, 1'b1);
        wait_valid(lat);
        check({tag, "_latency"}, 192'(lat), 192'(LAT + 1));
        check({tag, "_payload"}, 192'(crc_data_in), 192'(p));
        compare_out(tag);
        finish_frame(tag);
    endtask

    localparam logic [175:0] P_BASIC = 176'hABCDEF0123456789FEDCBA9876543210ABCDEF123456;
    localparam logic [175:0] P_TWO   = 176'h0001000200030004000500060007000800090010FFFF;
    localparam logic [175:0] P_THREE = 176'h5A5AA5A5000011112222FFFF8000000173E4C0DE0BAD;

    initial begin
        int           lat;
        logic [191:0] held;
        logic [175:0] p_rand;
        logic         seen_valid;

        // Reset values, applied asynchronously before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 192'(out_valid), 192'(1'b0));
        check("rst_out_data", out_data, 192'(0));
        check("rst_crc_data_in", 192'(crc_data_in), 192'(0));
        check("rst_frame_cnt", 192'(frame_cnt), 192'(0));
        check("rst_err_echo", 192'(err_echo), 192'(1'b0));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 192'(in_ready), 192'(1'b1));

        // Basic frame
        run_frame("basic", P_BASIC, -1);
        check("basic_echo_payload", 192'(out_data[191:16]), 192'(P_BASIC));
        check("basic_err_echo", 192'(err_echo), 192'(1'b0));

        // Back-to-back frame with different data
        run_frame("second", P_TWO, -1);

        // Back-pressure: out_ready low for 20 cycles after out_valid rises
        out_ready = 1'b0;
        send_frame(P_THREE, -1, 1'b1);
        wait_valid(lat);
        check("bp_latency", 192'(lat), 192'(LAT + 1));
        compare_out("bp");
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 192'(out_valid), 192'(1'b1));
            check("bp_out_stable", out_data, held);
            check("bp_in_ready", 192'(in_ready), 192'(1'b0));
        end
        check("bp_frame_cnt_hold", 192'(frame_cnt), 192'(exp_cnt));
        out_ready = 1'b1;
        finish_frame("bp");

        // Input gap of 3 cycles after word 4
        run_frame("gap", P_BASIC, 4);

        // Abort after 6 words, with a word 1111 presented in the abort cycle
        for (int k = 0; k < 6; k++) send_word(P_TWO[175-16*k -: 16]);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1111;
        @(posedge clk); #1;
        in_abort = 1'b0;
        in_valid = 1'b0;
        run_frame("abort", P_THREE, -1);

        // Randomised payload
        p_rand = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
        run_frame("rand", p_rand, -1);

        // Engine echo error, then a good frame; flag must stay set
        inject = 1'b1;
        run_frame("echo_bad", P_BASIC, -1);
        check("echo_err_set", 192'(err_echo), 192'(1'b1));
        inject = 1'b0;
        run_frame("echo_after", P_TWO, -1);
        check("echo_err_sticky", 192'(err_echo), 192'(1'b1));

        // Reset in the middle of WAIT: no codeword expected from this frame
        send_frame(P_THREE, -1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 192'(out_valid), 192'(1'b0));
        check("mid_rst_out_data", out_data, 192'(0));
        check("mid_rst_crc_data_in", 192'(crc_data_in), 192'(0));
        check("mid_rst_frame_cnt", 192'(frame_cnt), 192'(0));
        check("mid_rst_err_echo", 192'(err_echo), 192'(1'b0));
        exp_cnt = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("mid_rst_no_out", 192'(seen_valid), 192'(1'b0));
        check("mid_rst_in_ready", 192'(in_ready), 192'(1'b1));

        // Frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
        run_frame("wrap", P_TWO, -1);
        check("wrap_zero", 192'(frame_cnt), 192'(16'h0000));

        check("queue_empty", 192'(exp_q.size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something above never returns
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
- Sequencer that feeds the shared crc_192bits engine (176-bit payload in, 192-bit payload+CRC codeword out).
- Packs a stream of 16-bit words into one 176-bit payload, then holds it stable on the engine input for the engine's latency.
- Captures the codeword and checks that the engine echoed the payload unchanged.
- Presents the codeword downstream with valid/ready back-pressure.

Parameters:
- WORD_W, 16, input word width.
- WORDS, 11, words per payload; WORD_W*WORDS must equal 176.
- CRC_LATENCY, 2, clk edges from a stable crc_data_in to a valid crc_data_out; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  16  payload word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  controller accepts a word this cycle.
- in_abort  in  1  discard the partial payload.
- crc_data_in  out  176  drives the engine's data_in.
- crc_data_out  in  192  the engine's data_out.
- out_data  out  192  captured codeword.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- frame_cnt  out  16  count of delivered codewords, wraps.
- err_echo  out  1  sticky flag: engine payload echo mismatch.

Behaviour:
- Reset (async, rst=1): state=FILL, word index=0, crc_data_in=0, out_data=0, out_valid=0, in_ready=1 (driven once rst deasserts), frame_cnt=0, err_echo=0, wait counter=0.
- FILL:
  - in_ready=1.
  - An accept is in_valid&in_ready at a rising edge.
  - Word k (k=0 first) is written to crc_data_in[175-16k -: 16]; the first word lands in the MSBs.
  - Other bits of crc_data_in hold their value.
  - The index increments per accept.
  - Accepting word k=10 moves to WAIT with the counter cleared. No accept occurs in WAIT.
- WAIT:
  - in_ready=0; crc_data_in is held constant.
  - The counter increments each edge.
  - At the edge where counter==CRC_LATENCY-1:
    - out_data <= crc_data_out.
    - If crc_data_out[191:16] != crc_data_in, set err_echo.
    - Go to OUT; out_valid=1 from the next cycle.
- OUT:
  - in_ready=0.
  - out_valid and out_data stay stable until out_valid&out_ready.
  - On that edge: out_valid<=0, frame_cnt<=frame_cnt+1 (0xFFFF wraps to 0x0000), index<=0, go to FILL.
  - crc_data_in keeps the old payload until overwritten word by word.
- in_abort:
  - In FILL: index<=0 at that edge; any word presented the same cycle is dropped, since abort has priority over accept.
  - In WAIT and OUT: ignored.
- err_echo clears only on rst.
- Throughput:
  - Minimum cycles per frame = 11 (fill) + CRC_LATENCY (wait) + 1 (out, with out_ready held high).
  - Back-to-back, in_ready returns in the cycle after the out handshake.
- Simultaneous events: out_ready is sampled only while out_valid=1; out_ready asserted earlier has no effect.
- Reset mid-operation: all state is abandoned immediately; no partial codeword is emitted.

Test Plan:
- Basic frame:
  - Stimulus: with out_ready=1, stream words ABCD,EF01,2345,6789,FEDC,BA98,7654,3210,ABCD,EF12,3456.
  - Required: crc_data_in = 176'hABCDEF0123456789FEDCBA9876543210ABCDEF123456.
  - Required: out_data equals the engine's codeword, out_data[191:16] equals that payload, out_valid occurs CRC_LATENCY+1 cycles after the last accept, frame_cnt=1, err_echo=0.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_valid stays 1, out_data does not change, in_ready=0 throughout.
  - Required: on out_ready=1, a single handshake occurs and frame_cnt increments by exactly 1.
- Input gaps:
  - Stimulus: drop in_valid for 3 cycles between words 4 and 5.
  - Required: the payload is identical to the basic case, with no duplicated or skipped words.
- Abort:
  - Stimulus: after 6 words, assert in_abort for one cycle together with in_valid and word 1111, then send 11 fresh words.
  - Required: the payload contains only the fresh 11 words, and 1111 is absent.
- Echo error:
  - Stimulus: the engine model flips crc_data_out[100].
  - Required: err_echo=1 after capture and stays 1 across later good frames until rst.
- Reset mid-WAIT, and wrap:
  - Stimulus: assert rst during WAIT.
  - Required: outputs return to reset values asynchronously, and no out_valid pulse appears.
  - Stimulus: preload 65535 frames (force or loop), then deliver one more.
  - Required: frame_cnt reads 0x0000.
